computie_bus_ad_phy: RTL

// Sequenced master PHY for the multiplexed address/data bus. Accepts one transaction at a time from the core side.

---
 rtl/computie_bus_pkg.sv | 18 +
 rtl/computie_bus_ad_pad.sv | 33 +++
 rtl/computie_bus_ad_phy.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/computie_bus_pkg.sv
// Shared definitions for the multiplexed address/data bus master PHY.
package computie_bus_pkg;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_RELEASE
    } bus_state_t;

    // bus_rw encoding on the pins.
    localparam logic BUS_RW_READ  = 1'b1;
    localparam logic BUS_RW_WRITE = 1'b0;

endpackage

// File: rtl/computie_bus_ad_pad.sv
// Tristate pad array for the AD pins: one SB_IO-style cell per bit
// (PIN_TYPE 6'b1010_00: combinational output enable and output data,
// input captured in the pad's input register).
module computie_bus_ad_pad #(
    parameter int BITWIDTH = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_oe,
    input  logic [BITWIDTH-1:0] i_dout,
    output logic [BITWIDTH-1:0] o_din,
    inout  wire  [BITWIDTH-1:0] io_pad
);

    logic [BITWIDTH-1:0] r_din;

    // Output enable is not registered, so an asynchronous reset of the
    // sequencer state releases the pins without waiting for a clock edge.
    assign io_pad = i_oe ? i_dout : {BITWIDTH{1'bz}};
    assign o_din  = r_din;

    // Input register: one capture stage for whatever is on the pins.
    always_ff @(posedge i_clock or posedge i_reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement or process order.
        if (i_reset) begin
            r_din <= '0;
        end else begin
            r_din <= io_pad;
        end
    end

endmodule

// File: rtl/computie_bus_ad_phy.sv
// Sequenced master PHY for the multiplexed AD bus: address phase, write data
// or turnaround + read data, ack synchronisation, timeout and release.
module computie_bus_ad_phy
    import computie_bus_pkg::*;
#(
    parameter int BITWIDTH    = 32,
    parameter int TURNAROUND  = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_write,
    input  logic [BITWIDTH-1:0] i_req_addr,
    input  logic [BITWIDTH-1:0] i_req_wdata,
    output logic                o_rsp_done,
    output logic                o_rsp_error,
    output logic [BITWIDTH-1:0] o_rsp_rdata,
    output logic                o_bus_as,
    output logic                o_bus_ds,
    output logic                o_bus_rw,
    input  logic                i_bus_ack,
    inout  wire  [BITWIDTH-1:0] io_pins_ad
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [3:0] TURN_LAST   = 4'(TURNAROUND - 1);

    bus_state_t             r_state;
    bus_state_t             w_state_next;
    logic [BITWIDTH-1:0]    r_addr;
    logic [BITWIDTH-1:0]    r_wdata;
    logic [BITWIDTH-1:0]    r_rdata;
    logic                   r_write;
    logic                   r_err;
    logic [7:0]             r_wait_cnt;
    logic [3:0]             r_turn_cnt;
    logic [SYNC_STAGES-1:0] r_ack_sync;

    logic                   w_ack_s;
    logic                   w_accept;
    logic                   w_in_data;
    logic                   w_timeout;
    logic                   w_oe;
    logic [BITWIDTH-1:0]    w_dout;
    logic [BITWIDTH-1:0]    w_ad_in_q;

    assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];
    assign o_req_ready = (r_state == ST_IDLE);
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_in_data   = (r_state == ST_WDATA) || (r_state == ST_RDATA);
    // An ack seen on the limit cycle beats the timeout.
    assign w_timeout   = (r_wait_cnt == TIMEOUT_CNT) & ~w_ack_s;
    assign o_rsp_error = o_rsp_done & r_err;
    assign o_rsp_rdata = r_rdata;

    computie_bus_ad_pad #(
        .BITWIDTH (BITWIDTH)
    ) u_pad (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_oe    (w_oe),
        .i_dout  (w_dout),
        .o_din   (w_ad_in_q),
        .io_pad  (io_pins_ad)
    );

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus strobes, pin drive and done, all from the state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        o_bus_as     = 1'b0;
        o_bus_ds     = 1'b0;
        o_bus_rw     = BUS_RW_READ;
        w_oe         = 1'b0;
        w_dout       = r_addr;
        o_rsp_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_ADDR;
            end
            ST_ADDR: begin
                w_oe         = 1'b1;
                o_bus_as     = 1'b1;
                o_bus_rw     = r_write ? BUS_RW_WRITE : BUS_RW_READ;
                w_state_next = r_write ? ST_WDATA : ST_TURN;
            end
            ST_WDATA: begin
                w_oe     = 1'b1;
                w_dout   = r_wdata;
                o_bus_as = 1'b1;
                o_bus_ds = 1'b1;
                o_bus_rw = BUS_RW_WRITE;
                if (w_ack_s || w_timeout) w_state_next = ST_RELEASE;
            end
            ST_TURN: begin
                o_bus_as = 1'b1;
                if (r_turn_cnt == TURN_LAST) w_state_next = ST_RDATA;
            end
            ST_RDATA: begin
                o_bus_as = 1'b1;
                o_bus_ds = 1'b1;
                if (w_ack_s || w_timeout) w_state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Hold here until the target drops ack; no timeout.
                if (!w_ack_s) begin
                    o_rsp_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Ack synchroniser, request latch, counters and response registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ack_sync <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
            r_turn_cnt <= '0;
            r_rdata    <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_bus_ack};

            if (w_accept) begin
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_write <= i_req_write;
                r_err   <= 1'b0;
            end

            // Wait counter starts at zero on the first data-phase cycle.
            if (!w_in_data) begin
                r_wait_cnt <= '0;
            end else if (w_state_next == r_state) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if (r_state == ST_TURN) begin
                r_turn_cnt <= r_turn_cnt + 4'd1;
            end else begin
                r_turn_cnt <= '0;
            end

            if (w_in_data && w_timeout) begin
                r_err <= 1'b1;
            end

            if (r_state == ST_RDATA && w_ack_s) begin
                r_rdata <= w_ad_in_q;
            end
        end
    end

endmodule
